bkram_sd_sequencer: RTL and testbench
=====================================

Name: bkram_sd_sequencer

Overview:
Sequences backup-RAM transfers between the on-chip backup RAM and the HPS-mounted save image, one 512-byte sector at a time through the sd_rd/sd_wr/sd_ack handshake. Also runs the format sequence, which writes the default header words into the backup RAM. It arbitrates the backup RAM's port B between the SD buffer path and the format writer. It sits between the OSD status bits, hps_io and the two backup RAM halves.

Parameters:
SECTORS, 16, sectors per slot; power of two, max 16; LBA low nibble wraps at SECTORS-1.
SLOT_BITS, 2, width of slot select; slot occupies sd_lba[SLOT_BITS+3:4].
TO_BITS, 20, width of ack-timeout counter; timeout fires when counter reaches all-ones.

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
enable  in  1  save image mounted and writable; requests ignored while 0.
load_req  in  1  level from OSD; rising edge starts a load.
save_req  in  1  level from OSD; rising edge starts a save.
format_req  in  1  level from OSD; rising edge starts a format.
slot  in  SLOT_BITS  save slot, sampled at transfer start.
sd_ack  in  1  hps_io sector acknowledge.
sd_lba  out  32  sector address to hps_io.
sd_rd  out  1  sector read request.
sd_wr  out  1  sector write request.
busy  out  1  transfer or format in progress; drives LED.
loading  out  1  high during a load; holds the core in reset.
port_sel  out  1  1 selects the SD buffer path on backup RAM port B; 0 selects the format writer.
fmt_we  out  1  format write strobe.
fmt_addr  out  2  format word address.
fmt_data  out  16  format word.
done  out  1  one-cycle pulse when a transfer completes normally.
error  out  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset: sd_lba=0, sd_rd=sd_wr=0, busy=loading=fmt_we=done=error=0, fmt_addr=0, fmt_data=0, port_sel=1, state IDLE, pending-format flag cleared. Edge-detect registers load so that a request level held through reset does not fire.
- Edges: each input gets a registered previous copy. sd_ack rise = ack & ~ack_d. sd_ack fall = ~ack & ack_d.
- States: IDLE, REQ, XFER, FMT.
- IDLE:
  - If enable and a load or save edge occurs: sd_lba={zeros, slot, 4'd0}; sd_rd=is_load, sd_wr=~is_load; loading=is_load; busy=1; go to REQ. All of these are registered, so visible the next cycle.
  - If load and save edges coincide, the load wins and the save is dropped.
  - Else if a format edge occurs or the pending flag is set: clear pending, port_sel=0, go to FMT. Format does not require enable.
- REQ:
  - Timeout counter increments each cycle.
  - On sd_ack rise: clear sd_rd/sd_wr, clear the counter, go to XFER.
  - If the counter reaches all-ones first: clear sd_rd/sd_wr/busy/loading, pulse error, go to IDLE.
- XFER:
  - Waits for sd_ack fall; no timeout in this state.
  - On the fall, if sd_lba[3:0]==SECTORS-1: clear busy and loading, pulse done, go to IDLE.
  - Otherwise: sd_lba+=1 (low nibble only, slot bits unchanged), reassert the same sd_rd/sd_wr, go to REQ.
- FMT:
  - Four consecutive cycles with fmt_we=1, fmt_addr 0..3, fmt_data 0x5548, 0x4D42, 0x8800, 0x8010.
  - After the fourth write: fmt_we=0, port_sel=1, busy=0, go to IDLE.
  - busy=1 throughout. Load/save edges during FMT are dropped.
- Format edge during REQ/XFER sets the pending flag; the format runs immediately after the transfer ends (done or error).
- sd_rd and sd_wr are never high simultaneously. Neither is high outside REQ.
- enable falling mid-transfer does not abort; the sequence completes or times out.
- reset_n asserted mid-operation clears everything asynchronously; a partial transfer is abandoned and no done or error pulse is produced.

Test Plan:
- Save, slot=2: save_req 0→1 → sd_wr=1, sd_lba=0x20. Ack each sector (3 cycles high) → 16 sectors 0x20..0x2F, loading=0 throughout, one done pulse after the last ack fall.
- Load and save edges on the same cycle, slot=0 → sd_rd=1, sd_wr=0, loading=1 until done. After 16 acks, sd_lba=0x0F.
- No ack after request (TO_BITS=4) → sd_rd drops after 15 cycles in REQ, error pulse, busy=0, loading=0.
- Format in idle → fmt_we high 4 cycles with (0,0x5548), (1,0x4D42), (2,0x8800), (3,0x8010); port_sel=0 during the writes, then 1.
- Format edge during sector 5 of a save → format runs right after the done pulse. A save edge issued during FMT produces no sd_wr.
- reset_n low mid-XFER with save_req still high → all outputs return to reset values immediately. After release, no new transfer starts until save_req toggles.

Source files
------------

// File: rtl/bkram_sd_sequencer.sv
// bkram_sd_sequencer
//
// Moves backup-RAM contents to and from the HPS save image one 512-byte
// sector at a time over the sd_rd/sd_wr/sd_ack handshake. It also runs the
// format sequence, which writes the four default header words into the
// backup RAM, and it arbitrates backup RAM port B between the SD buffer path
// and the format writer.
//
// Ports:
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   enable                    image mounted/writable; gates load/save starts
//   load_req/save_req         OSD levels; a rising edge starts a transfer
//   format_req                OSD level; a rising edge starts a format
//   slot                      save slot, sampled when a transfer starts
//   sd_ack                    hps_io sector acknowledge
//   sd_lba, sd_rd, sd_wr      sector request to hps_io
//   busy, loading             activity LED / core hold-in-reset
//   port_sel                  1: SD buffer owns RAM port B, 0: format writer
//   fmt_we/fmt_addr/fmt_data  format writer port
//   done, error               one-cycle completion / ack-timeout pulses
module bkram_sd_sequencer #(
  parameter int unsigned SECTORS   = 16,
  parameter int unsigned SLOT_BITS = 2,
  parameter int unsigned TO_BITS   = 20
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic                 format_req,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic                 sd_ack,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  output logic                 busy,
  output logic                 loading,
  output logic                 port_sel,
  output logic                 fmt_we,
  output logic [1:0]           fmt_addr,
  output logic [15:0]          fmt_data,
  output logic                 done,
  output logic                 error
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StXfer = 2'd2;
  localparam logic [1:0] StFmt  = 2'd3;

  localparam logic [3:0]         LastSector = 4'(SECTORS - 1);
  localparam logic [TO_BITS-1:0] ToMax      = {TO_BITS{1'b1}};

  logic [1:0]         state_q, state_d;
  logic [31:0]        lba_q, lba_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               busy_q, busy_d;
  logic               loading_q, loading_d;
  logic               port_sel_q, port_sel_d;
  logic               fmt_we_q, fmt_we_d;
  logic [1:0]         fmt_addr_q, fmt_addr_d;
  logic [15:0]        fmt_data_q, fmt_data_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               pending_q, pending_d;
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
  logic               load_prev_q, save_prev_q, fmt_prev_q, ack_prev_q;

  logic               load_edge, save_edge, fmt_edge, ack_rise, ack_fall;
  logic [TO_BITS-1:0] to_cnt_inc;
  logic [1:0]         fmt_addr_nxt;
  logic [15:0]        fmt_word_nxt;

  assign load_edge  = load_req & ~load_prev_q;
  assign save_edge  = save_req & ~save_prev_q;
  assign fmt_edge   = format_req & ~fmt_prev_q;
  assign ack_rise   = sd_ack & ~ack_prev_q;
  assign ack_fall   = ~sd_ack & ack_prev_q;
  assign to_cnt_inc = to_cnt_q + TO_BITS'(1);

  // Header word for the next format write.
  assign fmt_addr_nxt = fmt_addr_q + 2'd1;
  always_comb begin
    fmt_word_nxt = 16'h5548;
    unique case (fmt_addr_nxt)
      2'd0: fmt_word_nxt = 16'h5548;
      2'd1: fmt_word_nxt = 16'h4D42;
      2'd2: fmt_word_nxt = 16'h8800;
      2'd3: fmt_word_nxt = 16'h8010;
      default: fmt_word_nxt = 16'h5548;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    lba_d      = lba_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    busy_d     = busy_q;
    loading_d  = loading_q;
    port_sel_d = port_sel_q;
    fmt_we_d   = fmt_we_q;
    fmt_addr_d = fmt_addr_q;
    fmt_data_d = fmt_data_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    pending_d  = pending_q;
    to_cnt_d   = to_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (enable && (load_edge || save_edge)) begin
          // Load wins over a coincident save.
          lba_d     = 32'(slot) << 4;
          rd_d      = load_edge;
          wr_d      = ~load_edge;
          loading_d = load_edge;
          busy_d    = 1'b1;
          to_cnt_d  = '0;
          state_d   = StReq;
          // A format edge on the same cycle is kept for after the transfer.
          if (fmt_edge) pending_d = 1'b1;
        end else if (fmt_edge || pending_q) begin
          pending_d  = 1'b0;
          port_sel_d = 1'b0;
          busy_d     = 1'b1;
          fmt_we_d   = 1'b1;
          fmt_addr_d = 2'd0;
          fmt_data_d = 16'h5548;
          state_d    = StFmt;
        end
      end

      StReq: begin
        if (fmt_edge) pending_d = 1'b1;
        if (ack_rise) begin
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          to_cnt_d = '0;
          state_d  = StXfer;
        end else if (to_cnt_inc == ToMax) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          busy_d    = 1'b0;
          loading_d = 1'b0;
          error_d   = 1'b1;
          to_cnt_d  = '0;
          state_d   = StIdle;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end

      StXfer: begin
        if (fmt_edge) pending_d = 1'b1;
        if (ack_fall) begin
          if (lba_q[3:0] == LastSector) begin
            busy_d    = 1'b0;
            loading_d = 1'b0;
            done_d    = 1'b1;
            state_d   = StIdle;
          end else begin
            // Only the sector nibble advances; slot bits stay put.
            lba_d   = {lba_q[31:4], lba_q[3:0] + 4'd1};
            rd_d    = loading_q;
            wr_d    = ~loading_q;
            state_d = StReq;
          end
        end
      end

      StFmt: begin
        if (fmt_addr_q == 2'd3) begin
          fmt_we_d   = 1'b0;
          fmt_addr_d = 2'd0;
          fmt_data_d = 16'h0000;
          port_sel_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end else begin
          fmt_addr_d = fmt_addr_nxt;
          fmt_data_d = fmt_word_nxt;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      lba_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      loading_q   <= 1'b0;
      port_sel_q  <= 1'b1;
      fmt_we_q    <= 1'b0;
      fmt_addr_q  <= 2'd0;
      fmt_data_q  <= 16'h0000;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      pending_q   <= 1'b0;
      to_cnt_q    <= '0;
      // Requests read as "already high" so a level held through reset
      // cannot produce an edge on release.
      load_prev_q <= 1'b1;
      save_prev_q <= 1'b1;
      fmt_prev_q  <= 1'b1;
      ack_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lba_q       <= lba_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      loading_q   <= loading_d;
      port_sel_q  <= port_sel_d;
      fmt_we_q    <= fmt_we_d;
      fmt_addr_q  <= fmt_addr_d;
      fmt_data_q  <= fmt_data_d;
      done_q      <= done_d;
      error_q     <= error_d;
      pending_q   <= pending_d;
      to_cnt_q    <= to_cnt_d;
      load_prev_q <= load_req;
      save_prev_q <= save_req;
      fmt_prev_q  <= format_req;
      ack_prev_q  <= sd_ack;
    end
  end

  assign sd_lba   = lba_q;
  assign sd_rd    = rd_q;
  assign sd_wr    = wr_q;
  assign busy     = busy_q;
  assign loading  = loading_q;
  assign port_sel = port_sel_q;
  assign fmt_we   = fmt_we_q;
  assign fmt_addr = fmt_addr_q;
  assign fmt_data = fmt_data_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_bkram_sd_sequencer.sv
// Directed testbench for bkram_sd_sequencer (TO_BITS=4 for a short timeout).
module tb_bkram_sd_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        enable, load_req, save_req, format_req, sd_ack;
  logic [1:0]  slot;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, busy, loading, port_sel, fmt_we, done, error;
  logic [1:0]  fmt_addr;
  logic [15:0] fmt_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  bkram_sd_sequencer #(
    .SECTORS  (16),
    .SLOT_BITS(2),
    .TO_BITS  (4)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .enable    (enable),
    .load_req  (load_req),
    .save_req  (save_req),
    .format_req(format_req),
    .slot      (slot),
    .sd_ack    (sd_ack),
    .sd_lba    (sd_lba),
    .sd_rd     (sd_rd),
    .sd_wr     (sd_wr),
    .busy      (busy),
    .loading   (loading),
    .port_sel  (port_sel),
    .fmt_we    (fmt_we),
    .fmt_addr  (fmt_addr),
    .fmt_data  (fmt_data),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    logic        load;
    logic        save;
    logic        fmt;
    logic        en;
    logic [1:0]  slot;
    logic        rd;
    logic        wr;
    logic        busy;
    logic        loading;
    logic        psel;
    logic        we;
    logic [1:0]  faddr;
    logic [15:0] fdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    chk("rd_wr_exclusive", 32'(sd_rd & sd_wr), 0);
  endtask

  // Serve one sector: verify the request, ack high 3 cycles, then drop it.
  task automatic ack_sector(input logic exp_rd, input logic exp_wr,
                            input logic [31:0] exp_lba, input logic exp_load);
    chk("req_rd", 32'(sd_rd), 32'(exp_rd));
    chk("req_wr", 32'(sd_wr), 32'(exp_wr));
    chk("req_lba", sd_lba, exp_lba);
    chk("req_loading", 32'(loading), 32'(exp_load));
    chk("req_busy", 32'(busy), 1);
    sd_ack = 1'b1;
    tick();
    chk("xfer_rdwr_low", 32'({sd_rd, sd_wr}), 0);
    tick();
    tick();
    sd_ack = 1'b0;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lba"}, sd_lba, 0);
    chk({tag, "_rdwr"}, 32'({sd_rd, sd_wr}), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_loading"}, 32'(loading), 0);
    chk({tag, "_fmt_we"}, 32'(fmt_we), 0);
    chk({tag, "_fmt_addr"}, 32'(fmt_addr), 0);
    chk({tag, "_fmt_data"}, 32'(fmt_data), 0);
    chk({tag, "_port_sel"}, 32'(port_sel), 1);
    chk({tag, "_done_err"}, 32'({done, error}), 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    load_req   = 1'b0;
    save_req   = 1'b0;
    format_req = 1'b0;
    sd_ack     = 1'b0;
    slot       = 2'd0;

    // Load with enable low is ignored; format runs without enable.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'h5548};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'h4D42};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 16'h8800};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 16'h8010};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0};

    // Reset values.
    tick();
    tick();
    chk_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      load_req   = vecs[i].load;
      save_req   = vecs[i].save;
      format_req = vecs[i].fmt;
      enable     = vecs[i].en;
      slot       = vecs[i].slot;
      tick();
      chk($sformatf("vec%0d_rd", i), 32'(sd_rd), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_wr", i), 32'(sd_wr), 32'(vecs[i].wr));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_loading", i), 32'(loading), 32'(vecs[i].loading));
      chk($sformatf("vec%0d_port_sel", i), 32'(port_sel), 32'(vecs[i].psel));
      chk($sformatf("vec%0d_fmt_we", i), 32'(fmt_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d_lba", i), sd_lba, 0);
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_fmt_addr", i), 32'(fmt_addr), 32'(vecs[i].faddr));
        chk($sformatf("vec%0d_fmt_data", i), 32'(fmt_data), 32'(vecs[i].fdata));
      end
    end

    // Save, slot 2: sectors 0x20..0x2F, one done pulse at the end.
    enable   = 1'b1;
    slot     = 2'd2;
    save_req = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      ack_sector(1'b0, 1'b1, 32'h20 + 32'(i), 1'b0);
      if (i < 15) chk("save_no_early_done", 32'(done), 0);
    end
    chk("save_done", 32'(done), 1);
    chk("save_busy_clr", 32'(busy), 0);
    tick();
    chk("save_done_pulse", 32'(done), 0);
    save_req = 1'b0;
    tick();

    // Coincident load and save, slot 0: load wins.
    slot     = 2'd0;
    load_req = 1'b1;
    save_req = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) ack_sector(1'b1, 1'b0, 32'(i), 1'b1);
    chk("load_done", 32'(done), 1);
    chk("load_loading_clr", 32'(loading), 0);
    chk("load_final_lba", sd_lba, 32'h0F);
    load_req = 1'b0;
    save_req = 1'b0;
    tick();

    // No ack: sd_rd held 15 cycles, then error pulse.
    slot     = 2'd1;
    load_req = 1'b1;
    tick();
    chk("to_lba", sd_lba, 32'h10);
    for (int k = 1; k < 15; k++) begin
      chk("to_rd_held", 32'(sd_rd), 1);
      chk("to_no_error", 32'(error), 0);
      tick();
    end
    chk("to_rd_last", 32'(sd_rd), 1);
    tick();
    chk("to_rd_drop", 32'(sd_rd), 0);
    chk("to_error", 32'(error), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_loading", 32'(loading), 0);
    tick();
    chk("to_error_pulse", 32'(error), 0);
    load_req = 1'b0;
    tick();

    // Format edge during sector 5 of a save runs after done; save in FMT dropped.
    slot     = 2'd0;
    save_req = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        format_req = 1'b1;
        tick();
        format_req = 1'b0;
      end
      ack_sector(1'b0, 1'b1, 32'(i), 1'b0);
      if (i < 15) chk("pend_no_fmt_we", 32'(fmt_we), 0);
    end
    chk("pend_done", 32'(done), 1);
    chk("pend_port_sel_hold", 32'(port_sel), 1);
    tick();
    chk("pend_fmt_we", 32'(fmt_we), 1);
    chk("pend_fmt_addr0", 32'(fmt_addr), 0);
    chk("pend_port_sel", 32'(port_sel), 0);
    save_req = 1'b0;
    tick();
    chk("pend_fmt_addr1", 32'(fmt_addr), 1);
    save_req = 1'b1;
    tick();
    chk("pend_fmt_addr2", 32'(fmt_addr), 2);
    tick();
    chk("pend_fmt_data3", 32'(fmt_data), 32'h8010);
    tick();
    chk("pend_fmt_end", 32'({fmt_we, port_sel, busy}), 32'b010);
    tick();
    chk("fmt_save_dropped", 32'({sd_wr, busy}), 0);

    // Reset mid-XFER with save_req held high.
    save_req = 1'b0;
    tick();
    save_req = 1'b1;
    tick();
    chk("rst_pre_wr", 32'(sd_wr), 1);
    sd_ack = 1'b1;
    tick();
    chk("rst_pre_xfer_busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    sd_ack = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_no_restart", 32'({sd_wr, busy, done, error}), 0);
    end
    save_req = 1'b0;
    tick();
    save_req = 1'b1;
    tick();
    chk("rst_retoggle_wr", 32'(sd_wr), 1);
    chk("rst_retoggle_lba", sd_lba, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
